// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and fetch state encoding for the RV32 fetch stage.
package riscv_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} fetch_state_e;
endpackage

// File: rtl/riscv_fetch_fifo.sv
// riscv_fetch_fifo: synchronous prefetch FIFO; flush wins over a same-cycle push.
module riscv_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] rd_q, rd_d, wr_q, wr_d;
    logic do_push, do_pop;
    assign count = wr_q - rd_q;
    assign empty = count == '0;
    assign head = mem_q[rd_q[AW-1:0]];
    assign do_pop = pop & ~empty;
    assign do_push = push & ~flush;
    always_comb begin
        rd_d = flush ? '0 : rd_q + (AW+1)'(do_pop);
        wr_d = flush ? '0 : wr_q + (AW+1)'(do_push);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
            wr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
            if (do_push) mem_q[wr_q[AW-1:0]] <= din;
        end
    end
    // the upstream request rule guarantees a free slot for every response
    assert property (@(posedge clk) disable iff (!rst_n) !(do_push && !do_pop && count == (AW+1)'(DEPTH)));
endmodule

// File: rtl/riscv_fetch.sv
// riscv_fetch: RV32 fetch stage with prefetch FIFO, redirect and wrong-path response discard.
// Define FETCH_MISALIGN_FAULT_EN to present misaligned redirect targets as fault entries.
module riscv_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] instr,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        fetch_fault
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    fetch_state_e state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d, redir_pc_q, redir_pc_d, resp_pc_q, resp_pc_d, target;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, fifo_count;
    logic en_q, pend_q, pend_d, redir_pend_q, redir_pend_d;
    logic fire, redirect, gnt, push, pop, fifo_empty;
    logic [63:0] head;

    // en_q keeps the bus quiet while reset is asserted and for the release cycle
    assign imem_req = en_q & (pend_q | (state_q == RUN &&
                      ({1'b0, out_q} + {1'b0, fifo_count}) < (CW+1)'(BUF_DEPTH)));
    assign imem_addr = fetch_pc_q;
    assign fire = instr_valid & instr_ready;
    assign redirect = fire & jump;
    assign gnt = imem_req & imem_gnt;
    assign target = jump_target & ~32'h3;
    assign push = imem_rvalid & (disc_q == '0) & (state_q == RUN);
    assign pop = fire & (state_q == RUN);

`ifdef FETCH_MISALIGN_FAULT_EN
    logic [31:0] fault_pc_q;
    assign state_d = redirect ? (|jump_target[1:0] ? FAULT : RUN) : state_q;
    assign fetch_fault = state_q == FAULT;
    assign instr_valid = fetch_fault | ~fifo_empty;
    assign pc = fetch_fault ? fault_pc_q : head[63:32];
    assign instr = fetch_fault ? NOP_INSTR : head[31:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_pc_q <= RESET_PC;
        else if (redirect) fault_pc_q <= jump_target;
    end
`else
    assign state_d = RUN;
    assign fetch_fault = 1'b0;
    assign instr_valid = ~fifo_empty;
    assign pc = head[63:32];
    assign instr = head[31:0];
`endif

    // a request held across a redirect keeps its old address; the target is applied at its grant
    always_comb begin
        out_d = out_q + CW'(gnt) - CW'(imem_rvalid);
        pend_d = imem_req & ~imem_gnt;
        disc_d = redirect ? out_d + CW'(pend_d) : disc_q - CW'(imem_rvalid && disc_q != '0);
        redir_pend_d = redirect ? pend_d : redir_pend_q & ~gnt;
        redir_pc_d = redirect ? target : redir_pc_q;
        fetch_pc_d = (redirect && !pend_d) ? target :
                     gnt ? (redir_pend_q ? redir_pc_q : fetch_pc_q + 32'd4) : fetch_pc_q;
        resp_pc_d = redirect ? target : push ? resp_pc_q + 32'd4 : resp_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fetch_pc_q <= RESET_PC;
            redir_pc_q <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q <= '0;
            disc_q <= '0;
            en_q <= 1'b0;
            pend_q <= 1'b0;
            redir_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            redir_pc_q <= redir_pc_d;
            resp_pc_q <= resp_pc_d;
            out_q <= out_d;
            disc_q <= disc_d;
            en_q <= 1'b1;
            pend_q <= pend_d;
            redir_pend_q <= redir_pend_d;
        end
    end

    riscv_fetch_fifo #(
        .DEPTH(BUF_DEPTH),
        .WIDTH(64),
        .INIT({RESET_PC, 32'h0})
    ) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .flush(redirect),
        .din({resp_pc_q, imem_rdata}),
        .empty(fifo_empty),
        .count(fifo_count),
        .head(head)
    );
endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: randomized bench comparing riscv_fetch against a program-order model of fetched words.
module tb_riscv_fetch;
    import riscv_pkg::*;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready, jump, fetch_fault;
    logic [31:0] imem_addr, imem_rdata, pc, instr, jump_target;

    riscv_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .instr(instr), .jump(jump), .jump_target(jump_target),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } resp_t;
    resp_t bus_q[$];
    int errors = 0, checks = 0, cyc = 0, consumed = 0;
    int gnt_pct, lat_min, lat_max, rdy_pct, jmp_pct, force_cond;
    bit force_jump, jump_done, hold, first_seen, exp_fault;
    logic [31:0] force_target, hold_addr, exp_pc, fault_pc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t = $urandom & 32'h0000_FFFC;
        if ($urandom_range(3) == 0) t[1:0] = 2'($urandom_range(3, 1));
        return t;
    endfunction

    task automatic knobs(input int g, input int lmin, input int lmax, input int r, input int j);
        gnt_pct = g; lat_min = lmin; lat_max = lmax; rdy_pct = r; jmp_pct = j;
    endtask

    task automatic step();
        bit go;
        @(negedge clk);
        cyc++;
        if (hold) begin
            check_eq("req_held", 32'(imem_req), 32'd1);
            check_eq("addr_held", imem_addr, hold_addr);
        end
        if (exp_fault) check_eq("fault_no_new_req", 32'(imem_req & ~hold), 32'd0);
        if (imem_req && !first_seen) begin
            first_seen = 1'b1;
            check_eq("first_addr", imem_addr, RST_PC);
        end
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        if (bus_q.size() > 0 && bus_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata = mem_word(bus_q[0].addr);
            bus_q.delete(0);
        end
        imem_gnt = imem_req && ($urandom_range(99) < gnt_pct);
        if (imem_gnt) bus_q.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
        instr_ready = $urandom_range(99) < rdy_pct;
        jump = 1'b0;
        jump_target = $urandom;
        if (instr_valid && instr_ready) begin
            consumed++;
            if (exp_fault) begin
                check_eq("fault_flag", 32'(fetch_fault), 32'd1);
                check_eq("fault_pc", pc, fault_pc);
                check_eq("fault_instr", instr, NOP_INSTR);
            end else begin
                check_eq("fault_clear", 32'(fetch_fault), 32'd0);
                check_eq("pc", pc, exp_pc);
                check_eq("instr", instr, mem_word(exp_pc));
            end
            go = force_jump && (force_cond == 0 ||
                 (force_cond == 1 && imem_gnt && imem_rvalid) ||
                 (force_cond == 2 && bus_q.size() >= 2));
            if (go || (!force_jump && $urandom_range(99) < jmp_pct)) begin
                jump = 1'b1;
                jump_target = go ? force_target : rand_target();
                if (go) begin
                    force_jump = 1'b0;
                    jump_done = 1'b1;
                end
`ifdef FETCH_MISALIGN_FAULT_EN
                exp_fault = jump_target[1:0] != 2'b00;
                fault_pc = jump_target;
`else
                exp_fault = 1'b0;
`endif
                exp_pc = jump_target & ~32'h3;
            end else if (!exp_fault) begin
                exp_pc += 32'd4;
            end
        end
        hold = imem_req && !imem_gnt;
        hold_addr = imem_addr;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic redirect_to(input logic [31:0] t, input int cond, input int budget);
        force_target = t;
        force_cond = cond;
        force_jump = 1'b1;
        jump_done = 1'b0;
        for (int i = 0; i < budget && !jump_done; i++) step();
        check_eq("redirect_taken", 32'(jump_done), 32'd1);
        force_jump = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        instr_ready = 1'b0;
        jump = 1'b0;
        jump_target = 32'h0;
        bus_q.delete();
        hold = 1'b0;
        first_seen = 1'b0;
        exp_fault = 1'b0;
        force_jump = 1'b0;
        exp_pc = RST_PC;
        #1;
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_fault", 32'(fetch_fault), 32'd0);
        check_eq("rst_pc", pc, RST_PC);
        check_eq("rst_instr", instr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        apply_reset();
        knobs(100, 1, 1, 100, 0);
        run(10);
        n = consumed;
        run(10);
        check_eq("throughput", 32'(consumed - n), 32'd10);

        knobs(100, 1, 1, 0, 0);
        run(10);
        check_eq("stall_req_off", 32'(imem_req), 32'd0);
        check_eq("stall_valid", 32'(instr_valid), 32'd1);
        check_eq("stall_no_inflight", 32'(bus_q.size()), 32'd0);
        check_eq("stall_head_pc", pc, exp_pc);
        knobs(100, 1, 1, 100, 0);
        run(10);

        knobs(100, 5, 5, 100, 0);
        run(12);
        redirect_to(32'h0000_0100, 2, 60);
        run(30);

        knobs(100, 1, 1, 100, 0);
        run(6);
        redirect_to(32'h0000_0400, 1, 30);
        run(10);

        redirect_to(32'h0000_0202, 0, 30);
        knobs(100, 1, 1, 0, 0);
        run(8);
        check_eq("mis_valid", 32'(instr_valid), 32'd1);
`ifdef FETCH_MISALIGN_FAULT_EN
        check_eq("mis_fault", 32'(fetch_fault), 32'd1);
        check_eq("mis_pc", pc, 32'h0000_0202);
        check_eq("mis_instr", instr, NOP_INSTR);
        check_eq("mis_no_req", 32'(imem_req), 32'd0);
`else
        check_eq("mis_fault", 32'(fetch_fault), 32'd0);
        check_eq("mis_pc", pc, 32'h0000_0200);
        check_eq("mis_instr", instr, mem_word(32'h0000_0200));
`endif
        knobs(100, 1, 1, 100, 0);
        redirect_to(32'h0000_0300, 0, 30);
        run(10);

        redirect_to(32'hFFFF_FFF8, 0, 30);
        run(10);

        knobs(70, 1, 4, 70, 10);
        run(3000);

        knobs(100, 1, 1, 0, 0);
        run(6);
        check_eq("pre_reset_valid", 32'(instr_valid), 32'd1);
        apply_reset();
        knobs(100, 1, 1, 100, 0);
        run(10);
        check_eq("req_after_reset", 32'(first_seen), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
